// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline result accumulator.
//   acc_state_t   : frame FSM states
//   *_DEFAULT     : default data / accumulator / counter widths
//   FRAME_LEN_MIN : shortest frame; a programmed length of 0 maps to this
package pipeline_pkg;

  localparam int unsigned DW_DEFAULT    = 32;
  localparam int unsigned AW_DEFAULT    = 40;
  localparam int unsigned CW_DEFAULT    = 8;
  localparam int unsigned FRAME_LEN_MIN = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/pipeline_accum_if.sv
// Sample-in / frame-total-out bundle for pipeline_accum.
//   in_valid, in_data, in_ready : sample stream from the pipeline stage
//   frame_len                   : samples per frame (0 behaves as 1)
//   out_valid, out_data,
//   out_ovf, out_ready          : frame total towards the next stage
// master drives samples and takes totals; slave is the accumulator.
interface pipeline_accum_if import pipeline_pkg::*; #(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) ();

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [CW-1:0] frame_len;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic          out_ovf;
  logic          out_ready;

  modport master (
    output in_valid, in_data, frame_len, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, frame_len, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/frame_counter.sv
// Frame length latch and sample counter.
//   clk, reset : clock, asynchronous active-high reset
//   load       : first sample of a frame accepted (latches frame_len, cnt = 1)
//   inc        : further sample of the frame accepted (cnt++)
//   frame_len  : programmed length, 0 treated as 1
//   last       : the sample being accepted this cycle completes the frame
module frame_counter import pipeline_pkg::*; #(
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [CW-1:0] frame_len,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] eff_len;

  assign eff_len = (frame_len == '0) ? CW'(FRAME_LEN_MIN) : frame_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(1);
      len_q <= eff_len;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // On the first sample len_q is not loaded yet, so decide from the live length.
  assign last = load ? (eff_len == CW'(FRAME_LEN_MIN)) : (cnt_q + CW'(1) == len_q);

endmodule

// File: rtl/pipeline_accum.sv
// Sums a programmable number of consecutive pipeline results into one frame
// total and offers it on a valid/ready port, holding it under backpressure.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pipeline_accum_if slave (samples in, frame totals out)
//   busy       : a frame is in progress or a total is pending
module pipeline_accum import pipeline_pkg::*; #(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_accum_if.slave  bus,
  output logic             busy
);

  acc_state_t    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;

  logic          in_fire;
  logic          load;
  logic          inc;
  logic          last;
  logic [AW-1:0] in_ext;
  logic [AW:0]   sum;

  assign in_fire = bus.in_valid && bus.in_ready;
  assign load    = in_fire && (state_q == IDLE);
  assign inc     = in_fire && (state_q == ACC);
  assign in_ext  = AW'(bus.in_data);
  // Extra top bit is the wrap carry for the sticky overflow flag.
  assign sum     = {1'b0, acc_q} + {1'b0, in_ext};

  frame_counter #(
    .CW (CW)
  ) u_frame_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .inc       (inc),
    .frame_len (bus.frame_len),
    .last      (last)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          acc_d = in_ext;
          ovf_d = 1'b0;
          if (last) begin
            out_data_d = in_ext;
            out_ovf_d  = 1'b0;
            state_d    = HOLD;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (inc) begin
          acc_d = sum[AW-1:0];
          ovf_d = ovf_q | sum[AW];
          if (last) begin
            out_data_d = sum[AW-1:0];
            out_ovf_d  = ovf_q | sum[AW];
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pipeline_accum.sv
// Self-checking bench for pipeline_accum (AW = 33 so overflow is reachable).
// Accepted samples feed a frame model that pushes expected totals; output
// transfers pop and compare them.
module tb_pipeline_accum;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 33;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [AW-1:0] data;
    logic          ovf;
  } result_t;

  logic clk;
  logic reset;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  result_t sb[$];

  // Frame model state
  int            m_cnt = 0;
  int            m_len = 0;
  logic [AW-1:0] m_acc = '0;
  logic          m_ovf = 1'b0;

  pipeline_accum_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  pipeline_accum #(
    .DW (DW),
    .AW (AW),
    .CW (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one sample and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    int   guard = 0;
    logic took  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!took && guard < 50) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!took) check("send_timeout", 64'(guard), 64'd0);
    bus.in_valid = 1'b0;
  endtask

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [AW:0] t;
    result_t     r;
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          r = sb.pop_front();
          check("sb_data", 64'(bus.out_data), 64'(r.data));
          check("sb_ovf", 64'(bus.out_ovf), 64'(r.ovf));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (m_cnt == 0) begin
          m_len = (bus.frame_len == '0) ? 1 : int'(bus.frame_len);
          m_acc = AW'(bus.in_data);
          m_ovf = 1'b0;
          m_cnt = 1;
        end else begin
          t     = {1'b0, m_acc} + (AW + 1)'(bus.in_data);
          m_acc = t[AW-1:0];
          m_ovf = m_ovf | t[AW];
          m_cnt++;
        end
        if (m_cnt == m_len) begin
          sb.push_back('{data: m_acc, ovf: m_ovf});
          m_cnt = 0;
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.frame_len = '0;
    bus.out_ready = 1'b0;
    #3;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);

    // Two-sample frame, back to back
    bus.out_ready = 1'b1;
    bus.frame_len = 8'd2;
    send(32'd6);
    check("t1_busy_mid", 64'(busy), 64'd1);
    send(32'd6);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_data", 64'(bus.out_data), 64'd12);
    check("t1_in_ready_hold", 64'(bus.in_ready), 64'd0);
    tick(1);
    check("t1_valid_drop", 64'(bus.out_valid), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Length 0 behaves as length 1
    bus.frame_len = 8'd0;
    send(32'd7);
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_data", 64'(bus.out_data), 64'd7);
    tick(1);

    // Gaps between samples hold the count
    bus.frame_len = 8'd3;
    send(32'd1);
    tick(1);
    check("t3_gap_busy", 64'(busy), 64'd1);
    check("t3_gap_valid", 64'(bus.out_valid), 64'd0);
    send(32'd2);
    tick(1);
    check("t3_gap2_valid", 64'(bus.out_valid), 64'd0);
    send(32'd3);
    check("t3_data", 64'(bus.out_data), 64'd6);
    tick(1);

    // Wrap at 2^33 sets the sticky overflow flag
    bus.frame_len = 8'd3;
    send(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    check("t4_data", 64'(bus.out_data), 64'h0_FFFF_FFFD);
    check("t4_ovf", 64'(bus.out_ovf), 64'd1);
    tick(1);
    bus.frame_len = 8'd2;
    send(32'd1);
    send(32'd1);
    check("t4_next_ovf", 64'(bus.out_ovf), 64'd0);
    check("t4_next_data", 64'(bus.out_data), 64'd2);
    tick(1);

    // Backpressure: total held, offered sample not consumed
    bus.out_ready = 1'b0;
    bus.frame_len = 8'd2;
    send(32'd4);
    send(32'd5);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd8;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t5_hold_data", 64'(bus.out_data), 64'd9);
      check("t5_hold_in_ready", 64'(bus.in_ready), 64'd0);
      tick(1);
    end
    bus.out_ready = 1'b1;
    tick(1);
    check("t5_after_xfer_valid", 64'(bus.out_valid), 64'd0);
    check("t5_after_xfer_in_ready", 64'(bus.in_ready), 64'd1);
    check("t5_after_xfer_busy", 64'(busy), 64'd0);
    tick(1);
    bus.in_valid = 1'b0;
    check("t5_sample8_taken", 64'(busy), 64'd1);
    send(32'd1);
    check("t5_data", 64'(bus.out_data), 64'd9);
    tick(1);

    // Reset mid-frame drops the partial frame at once
    bus.frame_len = 8'd3;
    send(32'd1);
    #1;
    reset = 1'b1;
    m_cnt = 0;
    sb.delete();
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_out_data", 64'(bus.out_data), 64'd0);
    #1;
    reset = 1'b0;
    tick(1);
    bus.frame_len = 8'd2;
    send(32'd2);
    send(32'd2);
    check("t6_data", 64'(bus.out_data), 64'd4);
    tick(1);

    tick(2);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
